// File: rtl/ppu_pkg.sv
// Shared types and constants for the PPU VRAM data port.
package ppu_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WR,
    S_RD,
    S_DONE
  } ppu_vram_state_t;

  localparam int INC_1  = 1;
  localparam int INC_32 = 32;

  localparam logic [5:0] PAL_HI_DEF = 6'h3F;

endpackage

// File: rtl/ppu_vaddr_counter.sv
// Current VRAM address: direct load, deferred load while busy,
// and post-access increment by 1 or 32 with natural wrap.
module ppu_vaddr_counter
  import ppu_pkg::*;
#(
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_val,
  input  logic              hold_en,
  input  logic              step_en,
  input  logic              inc_32,
  output logic [ADDR_W-1:0] cur_addr
);

  logic [ADDR_W-1:0] cur_q, cur_d;
  logic [ADDR_W-1:0] pend_q, pend_d;
  logic              pend_v_q, pend_v_d;
  logic [ADDR_W-1:0] step;

  assign step = inc_32 ? ADDR_W'(INC_32) : ADDR_W'(INC_1);

  always_comb begin
    cur_d    = cur_q;
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    if (step_en) begin
      cur_d    = pend_v_q ? pend_q : cur_q + step;
      pend_v_d = 1'b0;
    end
    // A load in the completion cycle is the latest one, so it wins.
    if (load_en) begin
      if (hold_en && !step_en) begin
        pend_d   = load_val;
        pend_v_d = 1'b1;
      end else begin
        cur_d = load_val;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_q    <= '0;
      pend_q   <= '0;
      pend_v_q <= 1'b0;
    end else begin
      cur_q    <= cur_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
    end
  end

  assign cur_addr = cur_q;

endmodule

// File: rtl/ppu_vram_port.sv
// PPUDATA access engine: buffered VRAM reads, palette bypass,
// writes via req/ack, and address auto-increment.
module ppu_vram_port
  import ppu_pkg::*;
#(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 8,
  parameter logic [ADDR_W-9:0] PAL_HI = (ADDR_W-8)'(PAL_HI_DEF)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              addr_load_en,
  input  logic [ADDR_W-1:0] addr_load_val,
  input  logic              inc_32,
  input  logic              data_write_en,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_read_en,
  output logic [DATA_W-1:0] data_out,
  output logic              rd_valid,
  output logic              data_write_complete,
  output logic              busy,
  output logic              overrun,
  output logic [ADDR_W-1:0] cur_addr,
  output logic              vram_req,
  output logic              vram_we,
  output logic [ADDR_W-1:0] vram_addr,
  output logic [DATA_W-1:0] vram_wdata,
  input  logic [DATA_W-1:0] vram_rdata,
  input  logic              vram_ack
);

  ppu_vram_state_t   state_q, state_d;
  logic              acc_we_q, acc_we_d;
  logic              pal_q, pal_d;
  logic [ADDR_W-1:0] vaddr_q, vaddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rbuf_q, rbuf_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              rdv_q, rdv_d;
  logic              ovr_q, ovr_d;
  logic              drop;
  logic              ack_step;
  logic              is_pal;

  assign is_pal = (cur_addr[ADDR_W-1:8] == PAL_HI);

  always_comb begin
    state_d  = state_q;
    acc_we_d = acc_we_q;
    pal_d    = pal_q;
    vaddr_d  = vaddr_q;
    wdata_d  = wdata_q;
    rbuf_d   = rbuf_q;
    dout_d   = dout_q;
    rdv_d    = 1'b0;
    drop     = 1'b0;
    ack_step = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (data_write_en) begin
          acc_we_d = 1'b1;
          vaddr_d  = cur_addr;
          wdata_d  = data_in;
          state_d  = S_WR;
          drop     = data_read_en;
        end else if (data_read_en) begin
          acc_we_d = 1'b0;
          vaddr_d  = cur_addr;
          pal_d    = is_pal;
          state_d  = S_RD;
          // Non-palette reads return the stale buffer immediately.
          if (!is_pal) begin
            dout_d = rbuf_q;
            rdv_d  = 1'b1;
          end
        end
      end
      S_WR, S_RD: begin
        drop = data_write_en | data_read_en;
        if (vram_ack) begin
          state_d  = S_DONE;
          ack_step = 1'b1;
          if (state_q == S_RD) begin
            rbuf_d = vram_rdata;
            if (pal_q) begin
              dout_d = vram_rdata;
              rdv_d  = 1'b1;
            end
          end
        end
      end
      S_DONE: begin
        drop    = data_write_en | data_read_en;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    ovr_d = drop ? 1'b1 : (addr_load_en ? 1'b0 : ovr_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      acc_we_q <= 1'b0;
      pal_q    <= 1'b0;
      vaddr_q  <= '0;
      wdata_q  <= '0;
      rbuf_q   <= '0;
      dout_q   <= '0;
      rdv_q    <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_we_q <= acc_we_d;
      pal_q    <= pal_d;
      vaddr_q  <= vaddr_d;
      wdata_q  <= wdata_d;
      rbuf_q   <= rbuf_d;
      dout_q   <= dout_d;
      rdv_q    <= rdv_d;
      ovr_q    <= ovr_d;
    end
  end

  ppu_vaddr_counter #(
    .ADDR_W(ADDR_W)
  ) u_vaddr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_en  (addr_load_en),
    .load_val (addr_load_val),
    .hold_en  (vram_req),
    .step_en  (ack_step),
    .inc_32   (inc_32),
    .cur_addr (cur_addr)
  );

  assign vram_req            = (state_q == S_WR) || (state_q == S_RD);
  assign vram_we             = (state_q == S_WR);
  assign busy                = (state_q != S_IDLE);
  assign data_write_complete = (state_q == S_DONE) && acc_we_q;
  assign vram_addr           = vaddr_q;
  assign vram_wdata          = wdata_q;
  assign data_out            = dout_q;
  assign rd_valid            = rdv_q;
  assign overrun             = ovr_q;

endmodule

// File: tb/tb_ppu_vram_port.sv
// Randomised bench for ppu_vram_port against a behavioural
// model of the PPUDATA address/buffer rules and a VRAM responder.
module tb_ppu_vram_port;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        addr_load_en;
  logic [13:0] addr_load_val;
  logic        inc_32;
  logic        data_write_en;
  logic [7:0]  data_in;
  logic        data_read_en;
  logic [7:0]  data_out;
  logic        rd_valid;
  logic        data_write_complete;
  logic        busy;
  logic        overrun;
  logic [13:0] cur_addr;
  logic        vram_req;
  logic        vram_we;
  logic [13:0] vram_addr;
  logic [7:0]  vram_wdata;
  logic [7:0]  vram_rdata;
  logic        vram_ack;

  ppu_vram_port dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .addr_load_en        (addr_load_en),
    .addr_load_val       (addr_load_val),
    .inc_32              (inc_32),
    .data_write_en       (data_write_en),
    .data_in             (data_in),
    .data_read_en        (data_read_en),
    .data_out            (data_out),
    .rd_valid            (rd_valid),
    .data_write_complete (data_write_complete),
    .busy                (busy),
    .overrun             (overrun),
    .cur_addr            (cur_addr),
    .vram_req            (vram_req),
    .vram_we             (vram_we),
    .vram_addr           (vram_addr),
    .vram_wdata          (vram_wdata),
    .vram_rdata          (vram_rdata),
    .vram_ack            (vram_ack)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  logic [7:0]  mem [16384];
  int          lat = 0;
  int          wait_cnt;
  int          wr_cnt = 0, wc_cnt = 0, rv_cnt = 0, done_cnt = 0;
  logic [13:0] wr_addr, done_addr;
  logic [7:0]  wr_data, rv_data;

  logic [13:0] m_addr;
  logic [7:0]  m_buf;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // VRAM responder plus observation of output pulses.
  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 8'($urandom);
    mem[14'h2400] = 8'h11;
    mem[14'h2401] = 8'h22;
    mem[14'h3F05] = 8'h2C;
    vram_ack   = 1'b0;
    vram_rdata = 8'h00;
    wait_cnt   = 0;
    forever begin
      @(negedge clk);
      if (rd_valid) begin
        rv_cnt++;
        rv_data = data_out;
      end
      if (data_write_complete) wc_cnt++;
      if (busy && !vram_req) begin
        done_cnt++;
        done_addr = cur_addr;
      end
      vram_ack = 1'b0;
      if (rst_n && vram_req) begin
        if (wait_cnt >= lat) begin
          vram_ack   = 1'b1;
          vram_rdata = mem[vram_addr];
          if (vram_we) begin
            mem[vram_addr] = vram_wdata;
            wr_cnt++;
            wr_addr = vram_addr;
            wr_data = vram_wdata;
          end
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [13:0] next_addr(logic [13:0] a);
    int step;
    step = inc_32 ? 32 : 1;
    return 14'((int'(a) + step) % 16384);
  endfunction

  task automatic wait_idle();
    for (int i = 0; i < 64 && busy; i++) tick();
    chk("idle_timeout", busy, 0);
  endtask

  task automatic do_load(logic [13:0] a);
    addr_load_en  = 1'b1;
    addr_load_val = a;
    tick();
    addr_load_en = 1'b0;
    chk("load_cur", cur_addr, a);
    m_addr = a;
  endtask

  task automatic do_write(logic [7:0] d);
    int c0, w0, d0;
    logic [13:0] ea;
    c0 = wc_cnt; w0 = wr_cnt; d0 = done_cnt;
    ea = m_addr;
    data_write_en = 1'b1;
    data_in       = d;
    tick();
    data_write_en = 1'b0;
    chk("wr_req", vram_req, 1);
    chk("wr_we", vram_we, 1);
    wait_idle();
    m_addr = next_addr(m_addr);
    chk("wr_cmpl", wc_cnt - c0, 1);
    chk("wr_cnt", wr_cnt - w0, 1);
    chk("done_cnt", done_cnt - d0, 1);
    chk("wr_addr", wr_addr, ea);
    chk("wr_data", wr_data, d);
    chk("done_addr", done_addr, m_addr);
    chk("wr_cur", cur_addr, m_addr);
  endtask

  task automatic do_read(output logic [7:0] got);
    int r0;
    logic pal;
    logic [7:0] exp;
    pal = (m_addr >> 8) == 14'h3F;
    exp = pal ? mem[m_addr] : m_buf;
    r0 = rv_cnt;
    data_read_en = 1'b1;
    tick();
    data_read_en = 1'b0;
    chk("rd_req", vram_req, 1);
    if (!pal) begin
      chk("rd_early_v", rd_valid, 1);
      chk("rd_early_d", data_out, exp);
    end
    wait_idle();
    m_buf  = mem[m_addr];
    m_addr = next_addr(m_addr);
    chk("rd_pulses", rv_cnt - r0, 1);
    chk("rd_data", rv_data, exp);
    chk("rd_hold", data_out, exp);
    chk("rd_done_addr", done_addr, m_addr);
    chk("rd_cur", cur_addr, m_addr);
    got = rv_data;
  endtask

  logic [7:0]  r;
  logic [13:0] a0;
  int          c0, rv0;

  initial begin
    rst_n = 1'b0;
    addr_load_en = 1'b0; addr_load_val = '0;
    inc_32 = 1'b0;
    data_write_en = 1'b0; data_in = '0;
    data_read_en = 1'b0;
    m_addr = '0; m_buf = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cur", cur_addr, 0);
    chk("rst_dout", data_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_req", vram_req, 0);
    chk("rst_we", vram_we, 0);
    chk("rst_ovr", overrun, 0);
    chk("rst_rv", rd_valid, 0);
    chk("rst_wc", data_write_complete, 0);
    chk("rst_vaddr", vram_addr, 0);
    chk("rst_wdata", vram_wdata, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Buffered reads
    lat = 1;
    do_load(14'h2400);
    do_read(r); chk("buf_rd0", r, 8'h00);
    do_read(r); chk("buf_rd1", r, 8'h11);
    do_read(r); chk("buf_rd2", r, 8'h22);

    // Write burst
    lat = 2;
    do_load(14'h2000);
    do_write(8'hAA);
    do_write(8'hBB);
    chk("burst_cur", cur_addr, 14'h2002);
    chk("burst_m0", mem[14'h2000], 8'hAA);
    chk("burst_m1", mem[14'h2001], 8'hBB);

    // Palette bypass, then buffer content seen by a normal read
    lat = 0;
    do_load(14'h3F05);
    do_read(r); chk("pal_rd", r, 8'h2C);
    do_load(14'h0100);
    do_read(r); chk("pal_buf", r, 8'h2C);

    // Increment wrap cases
    inc_32 = 1'b1;
    do_load(14'h3FF0);
    do_write(8'h55);
    chk("wrap32", cur_addr, 14'h0010);
    inc_32 = 1'b0;
    do_load(14'h3FFF);
    do_write(8'h66);
    chk("wrap1", cur_addr, 14'h0000);

    // Write strobe while busy is dropped
    lat = 3;
    do_load(14'h0500);
    c0 = wc_cnt;
    data_write_en = 1'b1; data_in = 8'h77;
    tick();
    data_in = 8'h88;
    tick();
    data_write_en = 1'b0;
    chk("ovr_set", overrun, 1);
    wait_idle();
    chk("ovr_wc", wc_cnt - c0, 1);
    chk("ovr_wdata", wr_data, 8'h77);
    chk("ovr_waddr", wr_addr, 14'h0500);
    chk("ovr_cur", cur_addr, 14'h0501);

    // Address load while busy
    a0 = cur_addr;
    data_write_en = 1'b1; data_in = 8'h99;
    tick();
    data_write_en = 1'b0;
    addr_load_en = 1'b1; addr_load_val = 14'h1234;
    tick();
    addr_load_en = 1'b0;
    chk("pend_ovr_clr", overrun, 0);
    wait_idle();
    chk("pend_waddr", wr_addr, a0);
    chk("pend_cur", cur_addr, 14'h1234);
    m_addr = 14'h1234;

    // Simultaneous write and read in idle
    c0 = wc_cnt; rv0 = rv_cnt;
    data_write_en = 1'b1; data_read_en = 1'b1; data_in = 8'h3C;
    tick();
    data_write_en = 1'b0; data_read_en = 1'b0;
    chk("both_ovr", overrun, 1);
    chk("both_we", vram_we, 1);
    wait_idle();
    chk("both_wc", wc_cnt - c0, 1);
    chk("both_rv", rv_cnt - rv0, 0);
    chk("both_wa", wr_addr, 14'h1234);
    m_addr = next_addr(m_addr);
    chk("both_cur", cur_addr, m_addr);

    // Load and drop in the same cycle: set wins
    data_write_en = 1'b1; data_in = 8'h01;
    tick();
    data_write_en = 1'b0;
    addr_load_en = 1'b1; addr_load_val = 14'h0777;
    data_read_en = 1'b1;
    tick();
    addr_load_en = 1'b0; data_read_en = 1'b0;
    chk("setwin_ovr", overrun, 1);
    wait_idle();
    chk("setwin_cur", cur_addr, 14'h0777);
    m_addr = 14'h0777;
    do_load(14'h0800);
    chk("load_clr_ovr", overrun, 0);

    // Random traffic
    for (int k = 0; k < 120; k++) begin
      lat = $urandom_range(0, 3);
      inc_32 = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0: begin
          if ($urandom_range(0, 3) == 0)
            do_load({6'h3F, 8'($urandom)});
          else
            do_load(14'($urandom));
        end
        1, 2: do_write(8'($urandom));
        default: do_read(r);
      endcase
    end

    // Asynchronous reset during an outstanding access
    lat = 20;
    inc_32 = 1'b0;
    data_write_en = 1'b1; data_in = 8'hE7;
    tick();
    data_write_en = 1'b0;
    chk("ar_req_before", vram_req, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_req", vram_req, 0);
    chk("ar_busy", busy, 0);
    chk("ar_we", vram_we, 0);
    chk("ar_cur", cur_addr, 0);
    chk("ar_dout", data_out, 0);
    chk("ar_ovr", overrun, 0);
    chk("ar_vaddr", vram_addr, 0);
    chk("ar_wdata", vram_wdata, 0);
    @(negedge clk);
    rst_n = 1'b1;
    m_addr = '0; m_buf = '0;
    tick();
    chk("ar_idle", busy, 0);
    lat = 0;
    do_read(r);
    chk("ar_buf", r, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
